// File: rtl/catch_pkg.sv
// Shared types and constants for the catch game controller: FSM states, reset values,
// winner encodings and the cursor/ball overlap test.
package catch_pkg;

    typedef enum logic [2:0] {
        StPlay,
        StCheck,
        StAward,
        StDrawX,
        StDrawY,
        StVerify,
        StWin
    } state_e;

    localparam logic [15:0] BallRstX   = 16'd300;
    localparam logic [15:0] BallRstY   = 16'd300;
    localparam logic [7:0]  P1ColorRst = 8'hE6;
    localparam logic [7:0]  P2ColorRst = 8'h2B;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;

    // Sums are carried in 17 bits so a cursor near 16'hFFFF cannot wrap into a false hit.
    function automatic logic overlaps(input logic [15:0] bx, input logic [15:0] by,
                                      input logic [15:0] px, input logic [15:0] py,
                                      input logic [16:0] size);
        return ({1'b0, bx} >= {1'b0, px}) && ({1'b0, bx} <= ({1'b0, px} + size)) &&
               ({1'b0, by} >= {1'b0, py}) && ({1'b0, by} <= ({1'b0, py} + size));
    endfunction

endpackage

// File: rtl/catch_lfsr.sv
// 10-bit Fibonacci LFSR, x^10 + x^7 + 1, free running with a synchronous clear to SEED.
module catch_lfsr #(
    parameter logic [9:0] SEED = 10'h1A5
) (
    input  logic       clk_i,
    input  logic       clr_i,
    output logic [9:0] lfsr_o
);

    logic [9:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/catch_game_ctrl.sv
// Per-frame catch game sequencer: catch detection, tie arbitration, scoring and ball respawn.
// Define CATCH_WIN_LIMIT_EN to enable the round-win screen (WIN state, winner, game_over).
module catch_game_ctrl
    import catch_pkg::*;
#(
    parameter int unsigned CURSOR_SIZE = 20,
    parameter int unsigned BALL_SIZE   = 10,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned WIN_FRAMES  = 120,
    parameter int unsigned MAX_RETRY   = 8,
    parameter logic [9:0]  LFSR_SEED   = 10'h1A5
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        frame_tick,
    input  logic [15:0] posx,
    input  logic [15:0] posy,
    input  logic [15:0] posx2,
    input  logic [15:0] posy2,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic [7:0]  player1_color,
    output logic [7:0]  player2_color,
    output logic [1:0]  winner,
    output logic        game_over
);

    localparam logic [9:0]  XSpan     = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [8:0]  YSpan     = 9'(V_ACTIVE - BALL_SIZE);
    localparam logic [16:0] CurSize   = 17'(CURSOR_SIZE);
    localparam logic [7:0]  RetryLast = 8'(MAX_RETRY - 1);

    state_e      state_q, state_d;
    logic        tick_q;
    logic        hit1_q, hit1_d, hit2_q, hit2_d;
    logic        tie_prio_q, tie_prio_d;  // 0: player 1 wins the next tie
    logic [15:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [3:0]  score1_q, score1_d, score2_q, score2_d;
    logic [7:0]  color1_q, color1_d, color2_q, color2_d;
    logic [9:0]  lfsr;
    logic        win1, cand_hit;

    catch_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i (dclk),
        .clr_i (clr),
        .lfsr_o(lfsr)
    );

`ifdef CATCH_WIN_LIMIT_EN
    logic [1:0]  winner_q, winner_d, win_pend_q, win_pend_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
`else
    logic unused_win_cfg;
    assign unused_win_cfg = ^{32'(WIN_SCORE), 32'(WIN_FRAMES)};
`endif

    always_comb begin
        state_d    = state_q;
        hit1_d     = hit1_q;
        hit2_d     = hit2_q;
        tie_prio_d = tie_prio_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        retry_d    = retry_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        color1_d   = color1_q;
        color2_d   = color2_q;
        win1       = hit1_q && (!hit2_q || !tie_prio_q);
        cand_hit   = overlaps(cand_x_q, cand_y_q, posx, posy, CurSize) ||
                     overlaps(cand_x_q, cand_y_q, posx2, posy2, CurSize);
`ifdef CATCH_WIN_LIMIT_EN
        winner_d    = winner_q;
        win_pend_d  = win_pend_q;
        frame_cnt_d = frame_cnt_q;
`endif
        case (state_q)
            StPlay: begin
                if (tick_q) state_d = StCheck;
            end
            StCheck: begin
                hit1_d  = overlaps(ball_x_q, ball_y_q, posx, posy, CurSize);
                hit2_d  = overlaps(ball_x_q, ball_y_q, posx2, posy2, CurSize);
                state_d = (hit1_d || hit2_d) ? StAward : StPlay;
            end
            StAward: begin
                if (hit1_q && hit2_q) tie_prio_d = ~tie_prio_q;
                if (win1) begin
                    score1_d = score1_q + 4'd1;
                    color1_d = color1_q + 8'd1;
`ifdef CATCH_WIN_LIMIT_EN
                    if (score1_d == 4'(WIN_SCORE)) win_pend_d = WinP1;
`endif
                end else begin
                    score2_d = score2_q + 4'd1;
                    color2_d = color2_q + 8'd1;
`ifdef CATCH_WIN_LIMIT_EN
                    if (score2_d == 4'(WIN_SCORE)) win_pend_d = WinP2;
`endif
                end
                state_d = StDrawX;
            end
            StDrawX: begin
                cand_x_d = {6'd0, (lfsr >= XSpan) ? lfsr - XSpan : lfsr};
                state_d  = StDrawY;
            end
            StDrawY: begin
                cand_y_d = {7'd0, (lfsr[8:0] >= YSpan) ? lfsr[8:0] - YSpan : lfsr[8:0]};
                state_d  = StVerify;
            end
            StVerify: begin
                if (cand_hit && (retry_q < RetryLast)) begin
                    retry_d = retry_q + 8'd1;
                    state_d = StDrawX;
                end else begin
                    ball_x_d = cand_x_q;
                    ball_y_d = cand_y_q;
                    retry_d  = 8'd0;
                    state_d  = StPlay;
`ifdef CATCH_WIN_LIMIT_EN
                    if (win_pend_q != WinNone) begin
                        winner_d    = win_pend_q;
                        win_pend_d  = WinNone;
                        frame_cnt_d = 16'd0;
                        state_d     = StWin;
                    end
`endif
                end
            end
`ifdef CATCH_WIN_LIMIT_EN
            StWin: begin
                if (tick_q) begin
                    if (frame_cnt_q == 16'(WIN_FRAMES - 1)) begin
                        score1_d = 4'd0;
                        score2_d = 4'd0;
                        color1_d = P1ColorRst;
                        color2_d = P2ColorRst;
                        winner_d = WinNone;
                        state_d  = StDrawX;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
`endif
            default: state_d = StPlay;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q    <= StPlay;
            tick_q     <= 1'b0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            tie_prio_q <= 1'b0;
            cand_x_q   <= 16'd0;
            cand_y_q   <= 16'd0;
            retry_q    <= 8'd0;
            ball_x_q   <= BallRstX;
            ball_y_q   <= BallRstY;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            color1_q   <= P1ColorRst;
            color2_q   <= P2ColorRst;
        end else begin
            state_q    <= state_d;
            tick_q     <= frame_tick;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            tie_prio_q <= tie_prio_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            retry_q    <= retry_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            color1_q   <= color1_d;
            color2_q   <= color2_d;
        end
    end

`ifdef CATCH_WIN_LIMIT_EN
    always_ff @(posedge dclk) begin
        if (clr) begin
            winner_q    <= WinNone;
            win_pend_q  <= WinNone;
            frame_cnt_q <= 16'd0;
        end else begin
            winner_q    <= winner_d;
            win_pend_q  <= win_pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign winner    = winner_q;
    assign game_over = (state_q == StWin);
`else
    assign winner    = WinNone;
    assign game_over = 1'b0;
`endif

    assign ball_x        = ball_x_q;
    assign ball_y        = ball_y_q;
    assign score1        = score1_q;
    assign score2        = score2_q;
    assign player1_color = color1_q;
    assign player2_color = color2_q;

endmodule

// File: tb/tb_catch_game_ctrl.sv
// Self-checking bench for catch_game_ctrl: table of single-frame vectors plus hand-written
// tie, retry-exhaustion, mid-flight clear and score-limit sequences.
module tb_catch_game_ctrl;

    localparam int         FAR  = -100000;
    localparam logic [9:0] SEED = 10'h1A5;

    logic        dclk = 1'b0, clr = 1'b1, frame_tick = 1'b0, tick_b = 1'b0;
    logic [15:0] posx = '0, posy = '0, posx2 = '0, posy2 = '0;
    logic [15:0] ball_x, ball_y, ball_x_b, ball_y_b;
    logic [3:0]  score1, score2, score1_b, score2_b;
    logic [7:0]  color1, color2, color1_b, color2_b;
    logic [1:0]  winner, winner_b;
    logic        game_over, game_over_b;

    int         checks = 0, failures = 0, cyc = 0;
    logic [9:0] lfsr_m = SEED;

    typedef struct {
        int edge_no;
        int px;
        int py;
        int x;
        int y;
        bit big;
    } commit_t;
    commit_t sb[$];

    typedef struct {
        int o1x;
        int o1y;
        int o2x;
        int o2y;
        int exp_w;
    } vec_t;
    vec_t rows[8];

    int e_s1[2], e_s2[2], e_c1[2], e_c2[2], eb_x[2], eb_y[2];

    catch_game_ctrl u_dut (
        .dclk(dclk), .clr(clr), .frame_tick(frame_tick),
        .posx(posx), .posy(posy), .posx2(posx2), .posy2(posy2),
        .ball_x(ball_x), .ball_y(ball_y), .score1(score1), .score2(score2),
        .player1_color(color1), .player2_color(color2),
        .winner(winner), .game_over(game_over)
    );

    // Cursors big enough to cover the whole field: every candidate overlaps.
    catch_game_ctrl #(
        .CURSOR_SIZE(700),
        .WIN_SCORE  (2)
    ) u_dut_big (
        .dclk(dclk), .clr(clr), .frame_tick(tick_b),
        .posx(16'd0), .posy(16'd0), .posx2(16'd0), .posy2(16'd0),
        .ball_x(ball_x_b), .ball_y(ball_y_b), .score1(score1_b), .score2(score2_b),
        .player1_color(color1_b), .player2_color(color2_b),
        .winner(winner_b), .game_over(game_over_b)
    );

    always #5 dclk = ~dclk;

    always @(posedge dclk) begin
        cyc    <= cyc + 1;
        lfsr_m <= clr ? SEED : {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [9:0] lstep(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic bit ovl(input int bx, input int by, input int px, input int py, input int cs);
        return (bx >= px) && (bx <= px + cs) && (by >= py) && (by <= py + cs);
    endfunction

    // lk is the LFSR value right after the tick edge; draws use the value three edges later.
    function automatic void predict(input logic [9:0] lk, input int p1x, input int p1y,
                                    input int p2x, input int p2y, input int cs,
                                    output int nx, output int ny, output int r);
        logic [9:0] l, lx, ly;
        int cx, cy;
        l = lstep(lstep(lstep(lk)));
        nx = 0; ny = 0; r = 0;
        for (int i = 0; i < 8; i++) begin
            lx = l;
            ly = lstep(l);
            l  = lstep(lstep(ly));
            cx = int'(lx);
            if (cx >= 630) cx -= 630;
            cy = int'(ly[8:0]);
            if (cy >= 470) cy -= 470;
            nx = cx; ny = cy; r = i;
            if (!(ovl(cx, cy, p1x, p1y, cs) || ovl(cx, cy, p2x, p2y, cs))) break;
        end
    endfunction

    // Scoreboard consumer: ball must hold its old value one edge before the commit edge.
    always @(posedge dclk) begin
        logic [15:0] ax, ay;
        #1;
        if (sb.size() > 0) begin
            ax = sb[0].big ? ball_x_b : ball_x;
            ay = sb[0].big ? ball_y_b : ball_y;
            if (cyc == sb[0].edge_no - 1) begin
                chk("ball_x before commit", 32'(ax), 32'(sb[0].px));
                chk("ball_y before commit", 32'(ay), 32'(sb[0].py));
            end else if (cyc >= sb[0].edge_no) begin
                chk("ball_x commit", 32'(ax), 32'(sb[0].x));
                chk("ball_y commit", 32'(ay), 32'(sb[0].y));
                chk("ball in range", 32'((ax < 630) && (ay < 470)), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic chk_outs(input bit big, input string nm);
        int b;
        b = big ? 1 : 0;
        chk({nm, " score1"}, 32'(big ? score1_b : score1), 32'(e_s1[b]));
        chk({nm, " score2"}, 32'(big ? score2_b : score2), 32'(e_s2[b]));
        chk({nm, " color1"}, 32'(big ? color1_b : color1), 32'(e_c1[b]));
        chk({nm, " color2"}, 32'(big ? color2_b : color2), 32'(e_c2[b]));
    endtask

    task automatic reset_all();
        @(negedge dclk) clr = 1'b1;
        repeat (2) @(posedge dclk);
        @(negedge dclk) clr = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            e_s1[i] = 0; e_s2[i] = 0; e_c1[i] = 'hE6; e_c2[i] = 'h2B;
            eb_x[i] = 300; eb_y[i] = 300;
        end
    endtask

    task automatic pulse(input bit big, output int k, output logic [9:0] lk);
        @(negedge dclk);
        if (big) tick_b = 1'b1; else frame_tick = 1'b1;
        @(posedge dclk);
        #1;
        k  = cyc;
        lk = lfsr_m;
        @(negedge dclk);
        frame_tick = 1'b0;
        tick_b     = 1'b0;
    endtask

    // Offsets place a cursor at (ball - offset); FAR parks it well away from the field.
    task automatic do_frame(input bit big, input int o1x, input int o1y, input int o2x,
                            input int o2y, input int exp_w, input string nm);
        int k, nx, ny, r, cs, b;
        int p[4];
        logic [9:0] lk;
        commit_t c;
        b = big ? 1 : 0;
        if (big) begin
            p = '{0, 0, 0, 0};
            cs = 700;
        end else begin
            cs = 20;
            p[0] = (o1x == FAR) ? 1000 : ((eb_x[0] - o1x) & 'hFFFF);
            p[1] = (o1x == FAR) ? 1000 : ((eb_y[0] - o1y) & 'hFFFF);
            p[2] = (o2x == FAR) ? 1000 : ((eb_x[0] - o2x) & 'hFFFF);
            p[3] = (o2x == FAR) ? 1000 : ((eb_y[0] - o2y) & 'hFFFF);
            posx = 16'(p[0]); posy = 16'(p[1]); posx2 = 16'(p[2]); posy2 = 16'(p[3]);
        end
        pulse(big, k, lk);
        if (exp_w == 1) begin
            e_s1[b] = (e_s1[b] + 1) % 16; e_c1[b] = (e_c1[b] + 1) % 256;
        end else if (exp_w == 2) begin
            e_s2[b] = (e_s2[b] + 1) % 16; e_c2[b] = (e_c2[b] + 1) % 256;
        end
        if (exp_w != 0) begin
            predict(lk, p[0], p[1], p[2], p[3], cs, nx, ny, r);
            c.edge_no = k + 6 + 3 * r; c.px = eb_x[b]; c.py = eb_y[b];
            c.x = nx; c.y = ny; c.big = big;
            sb.push_back(c);
            eb_x[b] = nx; eb_y[b] = ny;
        end
        repeat (3) @(posedge dclk);
        #1;
        chk_outs(big, nm);
        if (exp_w == 0) begin
            repeat (6) @(posedge dclk);
            #1;
            chk({nm, " ball_x held"}, 32'(big ? ball_x_b : ball_x), 32'(eb_x[b]));
            chk({nm, " ball_y held"}, 32'(big ? ball_y_b : ball_y), 32'(eb_y[b]));
        end
        repeat (40) @(posedge dclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [9:0] lk;

        rows[0] = '{5, 5, FAR, FAR, 1};
        rows[1] = '{FAR, FAR, 0, 0, 2};
        rows[2] = '{20, 20, FAR, FAR, 1};
        rows[3] = '{21, 0, 0, -1, 0};
        rows[4] = '{0, 20, -1, -1, 1};
        rows[5] = '{0, 0, 10, 10, 1};
        rows[6] = '{0, 21, 20, 0, 2};
        rows[7] = '{FAR, FAR, FAR, FAR, 0};

        reset_all();
        chk("rst ball_x", 32'(ball_x), 32'd300);
        chk("rst ball_y", 32'(ball_y), 32'd300);
        chk("rst score1", 32'(score1), 32'd0);
        chk("rst score2", 32'(score2), 32'd0);
        chk("rst color1", 32'(color1), 32'hE6);
        chk("rst color2", 32'(color2), 32'h2B);
        chk("rst winner", 32'(winner), 32'd0);
        chk("rst game_over", 32'(game_over), 32'd0);

        for (int i = 0; i < 8; i++) begin
            reset_all();
            do_frame(1'b0, rows[i].o1x, rows[i].o1y, rows[i].o2x, rows[i].o2y, rows[i].exp_w,
                     $sformatf("vec%0d", i));
        end

        // Tie priority alternates across consecutive double hits.
        reset_all();
        do_frame(1'b0, 0, 0, 0, 0, 1, "tie1");
        do_frame(1'b0, 0, 0, 0, 0, 2, "tie2");
        do_frame(1'b0, 0, 0, 0, 0, 1, "tie3");

        // Every candidate overlaps: commit lands after the last allowed draw.
        do_frame(1'b1, 0, 0, 0, 0, 1, "retry");

        // Clear while the respawn is in DRAW_Y.
        posx = 16'(eb_x[0]); posy = 16'(eb_y[0]); posx2 = 16'd1000; posy2 = 16'd1000;
        pulse(1'b0, k, lk);
        repeat (3) @(posedge dclk);
        #1;
        chk("clr pre score1", 32'(score1), 32'(e_s1[0] + 1));
        @(posedge dclk);
        @(negedge dclk) clr = 1'b1;
        @(posedge dclk);
        #1;
        chk("clr ball_x", 32'(ball_x), 32'd300);
        chk("clr ball_y", 32'(ball_y), 32'd300);
        chk("clr score1", 32'(score1), 32'd0);
        chk("clr color1", 32'(color1), 32'hE6);
        chk("clr winner", 32'(winner), 32'd0);
        chk("clr game_over", 32'(game_over), 32'd0);
        @(negedge dclk) clr = 1'b0;
        repeat (10) @(posedge dclk);
        #1;
        chk("clr no late commit x", 32'(ball_x), 32'd300);
        chk("clr no late commit y", 32'(ball_y), 32'd300);
        reset_all();

`ifdef CATCH_WIN_LIMIT_EN
        do_frame(1'b1, 0, 0, 0, 0, 1, "win1");
        do_frame(1'b1, 0, 0, 0, 0, 2, "win2");
        do_frame(1'b1, 0, 0, 0, 0, 1, "win3");
        chk("win game_over", 32'(game_over_b), 32'd1);
        chk("win winner", 32'(winner_b), 32'd1);
        for (int i = 0; i < 119; i++) begin
            pulse(1'b1, k, lk);
            repeat (3) @(posedge dclk);
        end
        #1;
        chk("win held game_over", 32'(game_over_b), 32'd1);
        pulse(1'b1, k, lk);
        repeat (2) @(posedge dclk);
        #1;
        chk("win exit game_over", 32'(game_over_b), 32'd0);
        chk("win exit winner", 32'(winner_b), 32'd0);
        e_s1[1] = 0; e_s2[1] = 0; e_c1[1] = 'hE6; e_c2[1] = 'h2B;
        chk_outs(1'b1, "win exit");
`else
        for (int i = 0; i < 16; i++) do_frame(1'b0, 0, 0, FAR, FAR, 1, $sformatf("wrap%0d", i));
        chk("wrap score1", 32'(score1), 32'd0);
        chk("wrap color1", 32'(color1), 32'hF6);
        chk("wrap game_over", 32'(game_over), 32'd0);
`endif

        repeat (5) @(posedge dclk);
        chk("pending commits", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
